line_pulse_gen: RTL and testbench
=================================

Name: line_pulse_gen

Overview:
- Generates the line-rate sync pulse train that drives the line pulse counter, plus a field-start marker and a divide-by-BLOCK_LINES square wave.
- Sits on the transmit/timing side of the PAL adaptation path.
- Replaces the external line pulse source in simulation and in self-timed builds.
- Its half_block output is the reference against which the line pulse counter output is checked.

Parameters:
LINE_CLKS, 64, clocks per line period (min 4)
PULSE_CLKS, 5, clocks line_pulse is high per line (1 .. LINE_CLKS-2)
LINES_PER_FIELD, 312, lines per field (min 2)
BLOCK_LINES, 50, lines per half_block period; must be even, min 2

Ports:
cp  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  advance enable; low holds all counters and outputs
line_pulse  out  1  line sync pulse, high PULSE_CLKS clocks at start of each line
field_start  out  1  high for the whole of line 0 of each field
half_block  out  1  low for lines 0..BLOCK_LINES/2-1 of each block, high for the rest
line_num  out  9  current line index, 0..LINES_PER_FIELD-1
busy  out  1  high once first enabled edge after reset has occurred

Behaviour:
- Interface: one clock `cp`; reset `rst` is synchronous and active-high.
- Counter widths: h_count holds 0..LINE_CLKS-1. blk_count holds 0..BLOCK_LINES-1. Width is $clog2 of the range, minimum 1.
- Reset values:
  - h_count = LINE_CLKS-1, line_num = LINES_PER_FIELD-1, blk_count = BLOCK_LINES-1.
  - line_pulse = 0, field_start = 0, half_block = 0, busy = 0.
- Reset takes priority over en on the same edge.
- Reset mid-line or mid-field returns to the reset state next edge; no partial pulse is completed.
- Enabled edge (en=1):
  - h_count increments; at LINE_CLKS-1 it wraps to 0 (line wrap).
  - On line wrap, line_num increments and wraps LINES_PER_FIELD-1 -> 0.
  - On line wrap, blk_count increments and wraps BLOCK_LINES-1 -> 0.
  - blk_count is free-running across field boundaries and is cleared only by rst.
  - busy is set to 1 and stays set until rst.
- Outputs are registered and reflect the counter values being loaded on the same edge. Zero added latency relative to the counters.
  - line_pulse = (new h_count < PULSE_CLKS).
  - field_start = (new line_num == 0).
  - half_block = (new blk_count >= BLOCK_LINES/2).
- Consequence: the first enabled edge after reset wraps all counters to 0 and asserts line_pulse and field_start. half_block = 0.
- en=0: every register holds its value. A pulse in progress is stretched by the number of held cycles. No pulse is dropped or duplicated.
- Falling edges of line_pulse are exactly LINE_CLKS enabled clocks apart. The counter counts these falling edges.
- A line_num value wider than 9 bits is a parameter error; the implementation issues a compile-time $error if LINES_PER_FIELD > 512.

Optional Feature:
- Macro: BROAD_PULSE_EN.
- Defined: during lines 0, 1 and 2 of each field, line_pulse is inverted (vertical serration / broad pulses).
  - It is low for h_count < PULSE_CLKS and high for the remainder of the line.
  - If LINES_PER_FIELD < 3, only the lines that exist are affected.
- Undefined: every line uses the normal pulse. The logic is absent; no extra ports.

Test Plan:
- Bench parameters for all scenarios: LINE_CLKS=8, PULSE_CLKS=2, LINES_PER_FIELD=6, BLOCK_LINES=4.
- Reset then en=1 for 48 clocks -> line_pulse high on clocks 1-2, 9-10, ..., 41-42. field_start high clocks 1-8 only. line_num steps 0..5. busy=1 from clock 1.
- en=1 for 100 clocks -> half_block sequence per line is 0,0,1,1,0,0,1,1,... across the field wrap at line 6. Verifies blk_count is not reset by field wrap.
- en dropped for 3 clocks while h_count=1 (line_pulse high) -> line_pulse stays high 3 extra clocks. The next rising edge is 8 enabled clocks after the previous one.
- rst asserted at line_num=3, h_count=5 with en=1 -> next edge all outputs 0, busy=0. The following enabled edge gives line_pulse=1, field_start=1, line_num=0.
- BROAD_PULSE_EN defined -> lines 0-2: line_pulse low on h_count 0-1, high on 2-7. Line 3 onward: normal pattern.
- Default parameters, 624 lines -> field_start asserted exactly twice, 312 lines apart. half_block toggles every 25 lines, continuous across the field wrap.

Source files
------------

// File: rtl/line_pulse_gen.sv
// rtl/line_pulse_gen.sv - line-rate sync pulse, field-start marker and half-block square wave generator
//
// Optional feature macro: BROAD_PULSE_EN
//   When defined, line_pulse is inverted during lines 0, 1 and 2 of each field
//   (vertical serration / broad pulses). When undefined, the logic is absent.
//
// All outputs are registered and are decoded from the next counter values, so
// they change on the same edge as the counters with no added latency.

module line_pulse_gen #(
   parameter int LINE_CLKS       = 64,
   parameter int PULSE_CLKS      = 5,
   parameter int LINES_PER_FIELD = 312,
   parameter int BLOCK_LINES     = 50
) (
   input  logic       cp,
   input  logic       rst,
   input  logic       en,
   output logic       line_pulse,
   output logic       field_start,
   output logic       half_block,
   output logic [8:0] line_num,
   output logic       busy
);

   // Counter widths: $clog2 of the range, never narrower than one bit.
   localparam int H_W = (LINE_CLKS   > 2) ? $clog2(LINE_CLKS)   : 1;
   localparam int B_W = (BLOCK_LINES > 2) ? $clog2(BLOCK_LINES) : 1;

   localparam logic [H_W-1:0] H_LAST  = H_W'(LINE_CLKS - 1);
   localparam logic [H_W-1:0] H_PULSE = H_W'(PULSE_CLKS);
   localparam logic [8:0]     L_LAST  = 9'(LINES_PER_FIELD - 1);
   localparam logic [B_W-1:0] B_LAST  = B_W'(BLOCK_LINES - 1);
   localparam logic [B_W-1:0] B_HALF  = B_W'(BLOCK_LINES / 2);

   // Elaboration-time parameter sanity checks.
   if (LINES_PER_FIELD > 512) begin : g_bad_lines_per_field
      $error("line_pulse_gen: LINES_PER_FIELD must not exceed 512 (line_num is 9 bits)");
   end
   if (LINES_PER_FIELD < 2) begin : g_small_lines_per_field
      $error("line_pulse_gen: LINES_PER_FIELD must be at least 2");
   end
   if (LINE_CLKS < 4) begin : g_bad_line_clks
      $error("line_pulse_gen: LINE_CLKS must be at least 4");
   end
   if ((PULSE_CLKS < 1) || (PULSE_CLKS > LINE_CLKS - 2)) begin : g_bad_pulse_clks
      $error("line_pulse_gen: PULSE_CLKS must be in 1 .. LINE_CLKS-2");
   end
   if ((BLOCK_LINES < 2) || ((BLOCK_LINES % 2) != 0)) begin : g_bad_block_lines
      $error("line_pulse_gen: BLOCK_LINES must be even and at least 2");
   end

   logic [H_W-1:0] h_count;
   logic [B_W-1:0] blk_count;

   logic           line_wrap;
   logic [H_W-1:0] h_next;
   logic [8:0]     line_next;
   logic [B_W-1:0] blk_next;
   logic           pulse_next;
   logic           field_next;
   logic           half_next;

   // Next counter values for an enabled edge; line and block advance on line wrap.
   always_comb begin
      line_wrap = (h_count == H_LAST);
      h_next    = line_wrap ? '0 : (h_count + H_W'(1));
      line_next = line_num;
      blk_next  = blk_count;
      if (line_wrap) begin
         line_next = (line_num  == L_LAST) ? '0 : (line_num + 9'd1);
         blk_next  = (blk_count == B_LAST) ? '0 : (blk_count + B_W'(1));
      end
   end

   // Output decode from the values about to be loaded into the counters.
   always_comb begin
      pulse_next = (h_next < H_PULSE);
`ifdef BROAD_PULSE_EN
      // Broad pulses: lines 0..2 carry the inverted pulse; fewer lines per
      // field simply means fewer affected lines.
      if (line_next < 9'd3) begin
         pulse_next = ~pulse_next;
      end
`else
`endif
      field_next = (line_next == 9'd0);
      half_next  = (blk_next >= B_HALF);
   end

   // Counter and output registers: reset wins over en, en=0 holds everything.
   always_ff @(posedge cp) begin
      if (rst) begin
         h_count     <= H_LAST;
         line_num    <= L_LAST;
         blk_count   <= B_LAST;
         line_pulse  <= 1'b0;
         field_start <= 1'b0;
         half_block  <= 1'b0;
         busy        <= 1'b0;
      end else if (en) begin
         h_count     <= h_next;
         line_num    <= line_next;
         blk_count   <= blk_next;
         line_pulse  <= pulse_next;
         field_start <= field_next;
         half_block  <= half_next;
         busy        <= 1'b1;
      end
   end

endmodule

// File: tb/tb_line_pulse_gen.sv
// tb/tb_line_pulse_gen.sv - directed self-checking bench for line_pulse_gen

module tb_line_pulse_gen;

   logic       cp = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       line_pulse, field_start, half_block, busy;
   logic [8:0] line_num;

   logic       rst2 = 1'b1;
   logic       en2 = 1'b0;
   logic       line_pulse2, field_start2, half_block2, busy2;
   logic [8:0] line_num2;

   int checks = 0;
   int errors = 0;
   int n = 0;   // enabled edges since last reset on the small instance

   always #5 cp = ~cp;

   line_pulse_gen #(
      .LINE_CLKS(8), .PULSE_CLKS(2), .LINES_PER_FIELD(6), .BLOCK_LINES(4)
   ) dut (
      .cp(cp), .rst(rst), .en(en),
      .line_pulse(line_pulse), .field_start(field_start), .half_block(half_block),
      .line_num(line_num), .busy(busy)
   );

   line_pulse_gen dut2 (
      .cp(cp), .rst(rst2), .en(en2),
      .line_pulse(line_pulse2), .field_start(field_start2), .half_block(half_block2),
      .line_num(line_num2), .busy(busy2)
   );

   // Expected values for the small instance after n enabled edges (n >= 1).
   function automatic logic exp_lp(int k);
      int  h  = (k - 1) % 8;
      int  ln = ((k - 1) / 8) % 6;
      logic p = (h < 2);
`ifdef BROAD_PULSE_EN
      if (ln < 3) p = ~p;
`endif
      return p;
   endfunction

   function automatic int exp_ln(int k);
      return ((k - 1) / 8) % 6;
   endfunction

   function automatic logic exp_hb(int k);
      return (((k - 1) / 8) % 4) >= 2;
   endfunction

   task automatic step();
      @(posedge cp);
      #1;
   endtask

   task automatic enabled_step();
      en = 1'b1;
      step();
      n++;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1;
      step();
      step();
      n = 0;
      checks += 5;
      if (line_pulse !== 1'b0) begin errors++; $display("FAIL reset_line_pulse got %b exp 0", line_pulse); end
      if (field_start !== 1'b0) begin errors++; $display("FAIL reset_field_start got %b exp 0", field_start); end
      if (half_block !== 1'b0) begin errors++; $display("FAIL reset_half_block got %b exp 0", half_block); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      if (line_num !== 9'd5) begin errors++; $display("FAIL reset_line_num got %0d exp 5", line_num); end
      rst = 1'b0; en = 1'b0;
      step();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", busy); end
   endtask

   task automatic test_first_field();
      for (int i = 0; i < 48; i++) begin
         enabled_step();
         checks += 4;
         if (line_pulse !== exp_lp(n)) begin errors++; $display("FAIL ff_line_pulse clk=%0d got %b exp %b", n, line_pulse, exp_lp(n)); end
         if (field_start !== (n <= 8)) begin errors++; $display("FAIL ff_field_start clk=%0d got %b exp %b", n, field_start, (n <= 8)); end
         if (line_num !== 9'(exp_ln(n))) begin errors++; $display("FAIL ff_line_num clk=%0d got %0d exp %0d", n, line_num, exp_ln(n)); end
         if (busy !== 1'b1) begin errors++; $display("FAIL ff_busy clk=%0d got %b exp 1", n, busy); end
      end
   endtask

   task automatic test_half_block();
      for (int i = 0; i < 100; i++) begin
         enabled_step();
         checks += 3;
         if (half_block !== exp_hb(n)) begin errors++; $display("FAIL hb_half_block clk=%0d got %b exp %b", n, half_block, exp_hb(n)); end
         if (line_num !== 9'(exp_ln(n))) begin errors++; $display("FAIL hb_line_num clk=%0d got %0d exp %0d", n, line_num, exp_ln(n)); end
         if (line_pulse !== exp_lp(n)) begin errors++; $display("FAIL hb_line_pulse clk=%0d got %b exp %b", n, line_pulse, exp_lp(n)); end
      end
   endtask

   task automatic test_stall();
      int high_clks;
      int gap;
      // advance to h_count=1 on a line outside the broad-pulse lines
      for (int i = 0; i < 64; i++) begin
         if (((n - 1) % 8 == 1) && (exp_ln(n) >= 3)) break;
         enabled_step();
      end
      checks++;
      if (line_pulse !== 1'b1) begin errors++; $display("FAIL stall_start got %b exp 1", line_pulse); end
      high_clks = 2;   // h_count 0 and 1 already shown high
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (line_pulse === 1'b1) high_clks++;
         checks += 2;
         if (line_pulse !== 1'b1) begin errors++; $display("FAIL stall_hold_pulse cyc=%0d got %b exp 1", i, line_pulse); end
         if (line_num !== 9'(exp_ln(n))) begin errors++; $display("FAIL stall_hold_line cyc=%0d got %0d exp %0d", i, line_num, exp_ln(n)); end
      end
      // remaining enabled clocks up to the next rising edge
      gap = 1;
      for (int i = 0; i < 16; i++) begin
         enabled_step();
         if (line_pulse === 1'b1) break;
         gap++;
      end
      checks += 2;
      if (high_clks !== 5) begin errors++; $display("FAIL stall_pulse_len got %0d exp 5", high_clks); end
      if (gap !== 7) begin errors++; $display("FAIL stall_rise_gap got %0d exp 7", gap); end
      // gap counts enabled edges after h=1 until next h=0: 6 more in line + wrap = 7; plus the h=1 edge itself gives 8
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 64; i++) begin
         if (((n - 1) % 8 == 5) && (exp_ln(n) == 3)) break;
         enabled_step();
      end
      checks += 2;
      if (line_num !== 9'd3) begin errors++; $display("FAIL mr_setup_line got %0d exp 3", line_num); end
      if (busy !== 1'b1) begin errors++; $display("FAIL mr_setup_busy got %b exp 1", busy); end
      rst = 1'b1; en = 1'b1;
      step();
      n = 0;
      checks += 5;
      if (line_pulse !== 1'b0) begin errors++; $display("FAIL mr_line_pulse got %b exp 0", line_pulse); end
      if (field_start !== 1'b0) begin errors++; $display("FAIL mr_field_start got %b exp 0", field_start); end
      if (half_block !== 1'b0) begin errors++; $display("FAIL mr_half_block got %b exp 0", half_block); end
      if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy got %b exp 0", busy); end
      if (line_num !== 9'd5) begin errors++; $display("FAIL mr_line_num got %0d exp 5", line_num); end
      rst = 1'b0;
      enabled_step();
      checks += 5;
      if (line_pulse !== exp_lp(1)) begin errors++; $display("FAIL mr_first_pulse got %b exp %b", line_pulse, exp_lp(1)); end
      if (field_start !== 1'b1) begin errors++; $display("FAIL mr_first_field got %b exp 1", field_start); end
      if (line_num !== 9'd0) begin errors++; $display("FAIL mr_first_line got %0d exp 0", line_num); end
      if (half_block !== 1'b0) begin errors++; $display("FAIL mr_first_half got %b exp 0", half_block); end
      if (busy !== 1'b1) begin errors++; $display("FAIL mr_first_busy got %b exp 1", busy); end
   endtask

   task automatic test_broad_lines();
      for (int i = 0; i < 47; i++) begin
         enabled_step();
         checks++;
         if (line_pulse !== exp_lp(n)) begin errors++; $display("FAIL bp_line_pulse clk=%0d got %b exp %b", n, line_pulse, exp_lp(n)); end
      end
   endtask

   task automatic test_default_params();
      int k;
      int rises;
      int first_rise;
      int second_rise;
      int fs_high;
      logic prev_fs;
      rst2 = 1'b1; en2 = 1'b1;
      step();
      rst2 = 1'b0;
      rises = 0; first_rise = 0; second_rise = 0; fs_high = 0; prev_fs = 1'b0;
      for (k = 1; k <= 624 * 64; k++) begin
         step();
         if (field_start2 === 1'b1) fs_high++;
         if ((field_start2 === 1'b1) && (prev_fs === 1'b0)) begin
            rises++;
            if (rises == 1) first_rise = k;
            if (rises == 2) second_rise = k;
         end
         prev_fs = field_start2;
         if ((k - 1) % 64 == 0) begin
            checks += 2;
            if (half_block2 !== ((((k - 1) / 64) % 50) >= 25)) begin
               errors++; $display("FAIL dp_half_block line=%0d got %b exp %b", (k - 1) / 64, half_block2, ((((k - 1) / 64) % 50) >= 25));
            end
            if (line_num2 !== 9'(((k - 1) / 64) % 312)) begin
               errors++; $display("FAIL dp_line_num line=%0d got %0d exp %0d", (k - 1) / 64, line_num2, ((k - 1) / 64) % 312);
            end
         end
      end
      en2 = 1'b0;
      checks += 4;
      if (rises !== 2) begin errors++; $display("FAIL dp_field_rises got %0d exp 2", rises); end
      if (first_rise !== 1) begin errors++; $display("FAIL dp_first_field got %0d exp 1", first_rise); end
      if (second_rise - first_rise !== 312 * 64) begin errors++; $display("FAIL dp_field_spacing got %0d exp %0d", second_rise - first_rise, 312 * 64); end
      if (fs_high !== 2 * 64) begin errors++; $display("FAIL dp_field_len got %0d exp %0d", fs_high, 2 * 64); end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout reached got running exp finished");
      $fatal(1, "timeout");
   end

   initial begin
      #1;
      test_reset();
      test_first_field();
      test_half_block();
      test_stall();
      test_mid_reset();
      test_broad_lines();
      test_default_params();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
